// File: rtl/display_pkg.sv
// display_pkg: types and constants shared by the display scheduler slice and
// the seven-segment display top level.
//   sched_state_t : scheduler FSM states
//   digits_t      : eight 4-bit digit values, digit g = word bits [4g+3:4g]
//   idx_width()   : index width for a requester count (minimum 1 bit)
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DWELL
  } sched_state_t;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned WORD_W     = 32;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// display_scheduler_if: requester-side and display-side signals of the
// display scheduler.
//   req, src_data, live, hold            : driven by the debug taps (master)
//   grant, ack, active_src, busy, bcds   : driven by the scheduler (slave)
interface display_scheduler_if #(
  parameter int unsigned NUM_SRC = 4
);
  import display_pkg::*;

  localparam int unsigned IDX_W = idx_width(NUM_SRC);

  logic [NUM_SRC-1:0]             req;
  logic [NUM_SRC-1:0][WORD_W-1:0] src_data;
  logic                           live;
  logic                           hold;
  logic [NUM_SRC-1:0]             grant;
  logic                           ack;
  logic [IDX_W-1:0]               active_src;
  logic                           busy;
  digits_t                        bcds;

  modport master (
    output req, src_data, live, hold,
    input  grant, ack, active_src, busy, bcds
  );

  modport slave (
    input  req, src_data, live, hold,
    output grant, ack, active_src, busy, bcds
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational circular first-one finder.
//   req   : request vector
//   ptr   : last winner; the scan starts at ptr+1 and wraps, ptr itself last
//   idx   : winning index (0 when none)
//   valid : at least one request present
module rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    int unsigned j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!valid && req[j[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin time-sharing of the 8-digit display between
// NUM_SRC debug requesters, each granted for DWELL_CYCLES after a 1-cycle LOAD.
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : display_scheduler_if.slave (req/src_data/live/hold in,
//           grant/ack/active_src/busy/bcds out, all outputs registered)
// Optional build macro DISPLAY_SCHED_PREEMPT_EN: source 0 preempts any other
// dwelling source, ignoring hold.
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input  logic                clock,
  input  logic                reset,
  display_scheduler_if.slave  bus
);

  localparam int unsigned     IDX_W   = idx_width(NUM_SRC);
  localparam int unsigned     CNT_W   = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   active_q, active_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [WORD_W-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  digits_t            bcds_q;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  // ptr_q is both the round-robin pointer and the current selection.
  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= IDX_W'(NUM_SRC - 1);
      active_q <= '0;
      grant_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      shadow_q <= '0;
      cnt_q    <= '0;
      bcds_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      bcds_q   <= digits_t'(shadow_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    active_d = active_q;
    grant_d  = grant_q;
    ack_d    = 1'b0;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = LOAD;
          ptr_d    = pick_idx;
          active_d = pick_idx;
        end
      end

      LOAD: begin
        grant_d        = '0;
        grant_d[ptr_q] = 1'b1;
        ack_d          = 1'b1;
        shadow_d       = bus.src_data[ptr_q];
        cnt_d          = '0;
        state_d        = DWELL;
      end

      DWELL: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (bus.live) shadow_d = bus.src_data[ptr_q];
        // Dwell end and early release share one exit; hold blocks both.
        // The old grant stays visible through the following LOAD cycle.
        if ((cnt_q == CNT_MAX || !bus.req[ptr_q]) && !bus.hold) begin
          if (pick_valid) begin
            state_d  = LOAD;
            ptr_d    = pick_idx;
            active_d = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
`ifdef DISPLAY_SCHED_PREEMPT_EN
        if (bus.req[0] && ptr_q != '0) begin
          state_d  = LOAD;
          ptr_d    = '0;
          active_d = '0;
        end
`endif
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.grant      = grant_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
  assign bus.active_src = active_q;
  assign bus.bcds       = bcds_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed and random stimulus for display_scheduler
// (NUM_SRC=4, DWELL_CYCLES=8) checked every cycle against a transaction-level
// reference model of owner / pending grant / dwell age.
module tb_display_scheduler;

  localparam int N     = 4;
  localparam int DWELL = 8;

  logic clock;
  logic reset;

  display_scheduler_if #(.NUM_SRC(N)) bus ();

  display_scheduler #(
    .NUM_SRC      (N),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: -1 means "none".
  int          m_owner;   // source whose grant is on the display
  int          m_next;    // source chosen, loads at the next edge
  int          m_ptr;
  int          m_active;
  int          m_age;     // dwell edges elapsed since load, saturating
  logic [31:0] m_shadow;
  logic [31:0] m_bcds;
  bit          m_ack;

  function automatic int rr_next(input logic [N-1:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      int c = (after + k) % N;
      if (r[c[1:0]]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return bus.src_data[i[1:0]];
  endfunction

  task automatic model_edge();
    int  pick;
    int  cur;
    bit  done;
    if (!reset) begin
      m_owner = -1; m_next = -1; m_ptr = N - 1; m_active = 0; m_age = 0;
      m_shadow = '0; m_bcds = '0; m_ack = 0;
      return;
    end
    m_bcds = m_shadow;
    m_ack  = 0;
    pick   = rr_next(bus.req, m_ptr);
    cur    = m_owner;
    if (m_next >= 0) begin
      m_owner  = m_next;
      m_next   = -1;
      m_ack    = 1;
      m_shadow = data_of(m_owner);
      m_age    = 0;
    end else if (cur >= 0) begin
      done = (m_age == DWELL - 1) || !bus.req[cur[1:0]];
      if (m_age < DWELL - 1) m_age++;
      if (bus.live) m_shadow = data_of(cur);
      if (done && !bus.hold) begin
        if (pick >= 0) begin
          m_next = pick; m_ptr = pick; m_active = pick;
        end else begin
          m_owner = -1;
        end
      end
`ifdef DISPLAY_SCHED_PREEMPT_EN
      if (bus.req[0] && cur != 0) begin
        m_next = 0; m_ptr = 0; m_active = 0;
      end
`endif
    end else if (pick >= 0) begin
      m_next = pick; m_ptr = pick; m_active = pick;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] g;
    g = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    chk("grant",      32'(bus.grant),      g);
    chk("ack",        32'(bus.ack),        32'(m_ack));
    chk("busy",       32'(bus.busy),       32'((m_owner >= 0) || (m_next >= 0)));
    chk("active_src", 32'(bus.active_src), m_active);
    chk("bcds",       32'(bus.bcds),       m_bcds);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.req      = '0;
    bus.live     = 1'b0;
    bus.hold     = 1'b0;
    for (int i = 0; i < N; i++) bus.src_data[i] = $urandom();

    // Reset state
    steps(2);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_bcds",  32'(bus.bcds),  32'd0);
    reset = 1'b1;

    // 1: single requester, latency and periodic re-grant
    bus.src_data[2] = 32'h1234ABCD;
    bus.req = 4'b0100;
    step();
    chk("t1_ack_early", 32'(bus.ack), 32'd0);
    step();
    chk("t1_ack",   32'(bus.ack),   32'd1);
    chk("t1_grant", 32'(bus.grant), 32'h4);
    step();
    chk("t1_bcds",  32'(bus.bcds),  32'h1234ABCD);
    steps(20);

    // 2: all four requesting, round-robin 0,1,2,3,0
    do_reset();
    bus.req = 4'b1111;
    steps(2);
    chk("t2_first", 32'(bus.grant), 32'h1);
    steps(9);
    chk("t2_second", 32'(bus.grant), 32'h2);
    steps(30);

    // 3: live=0 freezes the shadow, live=1 tracks src_data
    do_reset();
    bus.req = 4'b0010;
    steps(4);
    bus.src_data[1] = $urandom();
    steps(3);
    bus.live = 1'b1;
    bus.src_data[1] = $urandom();
    steps(3);
    bus.live = 1'b0;

    // 4: hold pins the current source past dwell end
    do_reset();
    bus.req  = 4'b0011;
    bus.hold = 1'b1;
    steps(30);
    chk("t4_held", 32'(bus.grant), 32'h1);
    bus.hold = 1'b0;
    steps(2);
    chk("t4_next", 32'(bus.grant), 32'h2);
    steps(10);

    // 5: early release to IDLE, then reset mid-dwell
    do_reset();
    bus.req = 4'b0001;
    steps(4);
    bus.req = 4'b0000;
    step();
    chk("t5_idle_grant", 32'(bus.grant), 32'd0);
    chk("t5_idle_busy",  32'(bus.busy),  32'd0);
    steps(3);
    bus.req = 4'b0001;
    steps(5);
    reset = 1'b0;
    step();
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_bcds", 32'(bus.bcds), 32'd0);
    reset = 1'b1;
    bus.req = 4'b0000;

    // 6: source 0 rising while source 2 dwells under hold
    do_reset();
    bus.req = 4'b0100;
    steps(4);
    bus.hold = 1'b1;
    bus.req  = 4'b0101;
    steps(2);
`ifdef DISPLAY_SCHED_PREEMPT_EN
    chk("t6_grant", 32'(bus.grant), 32'h1);
    chk("t6_ack",   32'(bus.ack),   32'd1);
`else
    chk("t6_grant", 32'(bus.grant), 32'h4);
    chk("t6_ack",   32'(bus.ack),   32'd0);
`endif
    steps(12);
    bus.hold = 1'b0;
    steps(12);

    // Random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom());
      bus.live = ($urandom_range(0, 3) == 0);
      bus.hold = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) bus.src_data[i] = $urandom();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
